// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns single ASCII command bytes from a UART receiver
// into stopwatch/watch control strobes. 'R' run/stop, 'C' clear, 'M' mode
// toggle, and "Thhmm" loads a time into the watch. Bad bytes, out-of-range
// times and stalled multi-byte commands pulse o_err.
module uart_cmd_decoder #(
  parameter int TIMEOUT_CLKS = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_set,
  output logic [4:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic       o_err
);

  // A one-clock timeout would give $clog2 of zero, so keep at least one bit.
  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    T_H1,
    T_H0,
    T_M1,
    T_M0
  } state_t;

  state_t      r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0]  r_h1, r_h0, r_m1;
  logic [3:0]  w_h1, w_h0, w_m1;

  logic        w_runStop, w_clear, w_mode, w_set, w_err;
  logic [4:0]  w_setHour;
  logic [5:0]  w_setMin;

  logic        w_isDigit;
  logic [3:0]  w_digit;
  logic [6:0]  w_hourSum, w_minSum;

  // Digit decode; the low nibble of '0'..'9' is already the digit value.
  // The ones-minute digit is used straight from the bus since the command
  // completes in the same cycle it arrives.
  assign w_isDigit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign w_digit   = rx_data[3:0];
  assign w_hourSum = 7'(r_h1) * 7'd10 + 7'(r_h0);
  assign w_minSum  = 7'(r_m1) * 7'd10 + 7'(w_digit);

  // State, timeout counter, digit registers and all outputs are registered
  // together; reset wins over any coincident byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_h1       <= '0;
      r_h0       <= '0;
      r_m1       <= '0;
      o_run_stop <= 1'b0;
      o_clear    <= 1'b0;
      o_mode     <= 1'b0;
      o_set      <= 1'b0;
      o_set_hour <= '0;
      o_set_min  <= '0;
      o_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_h1       <= w_h1;
      r_h0       <= w_h0;
      r_m1       <= w_m1;
      o_run_stop <= w_runStop;
      o_clear    <= w_clear;
      o_mode     <= w_mode;
      o_set      <= w_set;
      o_set_hour <= w_setHour;
      o_set_min  <= w_setMin;
      o_err      <= w_err;
    end
  end

  // Next-state and next-output decode. Pulses default low so each response
  // lasts exactly one cycle; a rejected byte in a time-set state is consumed
  // by the error and never reinterpreted as a fresh command.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_h1      = r_h1;
    w_h0      = r_h0;
    w_m1      = r_m1;
    w_runStop = 1'b0;
    w_clear   = 1'b0;
    w_mode    = o_mode;
    w_set     = 1'b0;
    w_err     = 1'b0;
    w_setHour = o_set_hour;
    w_setMin  = o_set_min;

    if (r_state == IDLE) begin
      w_cnt = '0;
      if (rx_done) begin
        case (rx_data)
          8'h52, 8'h72: w_runStop = 1'b1;
          8'h43, 8'h63: w_clear   = 1'b1;
          8'h4D, 8'h6D: w_mode    = ~o_mode;
          8'h54, 8'h74: w_state   = T_H1;
          8'h0D, 8'h0A: ;
          default:      w_err     = 1'b1;
        endcase
      end
    end else if (rx_done) begin
      w_cnt = '0;
      if (!w_isDigit) begin
        w_err   = 1'b1;
        w_state = IDLE;
      end else begin
        case (r_state)
          T_H1: begin
            w_h1    = w_digit;
            w_state = T_H0;
          end
          T_H0: begin
            w_h0    = w_digit;
            w_state = T_M1;
          end
          T_M1: begin
            w_m1    = w_digit;
            w_state = T_M0;
          end
          default: begin
            if ((w_hourSum <= 7'd23) && (w_minSum <= 7'd59)) begin
              w_set     = 1'b1;
              w_setHour = 5'(w_hourSum);
              w_setMin  = 6'(w_minSum);
            end else begin
              w_err = 1'b1;
            end
            w_state = IDLE;
          end
        endcase
      end
    end else if (r_cnt == TO_LAST) begin
      w_err   = 1'b1;
      w_state = IDLE;
      w_cnt   = '0;
    end else begin
      w_cnt = r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed vector table of command bytes with expected
// registered responses, plus hand-written sequences for reset, timeout and
// the byte-at-expiry race. Uses a 16-cycle timeout.
module tb_uart_cmd_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       o_run_stop;
  logic       o_clear;
  logic       o_mode;
  logic       o_set;
  logic [4:0] o_set_hour;
  logic [5:0] o_set_min;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       runStop;
    logic       clear;
    logic       set;
    logic       err;
    logic       mode;
    logic [4:0] hour;
    logic [5:0] min;
  } vec_t;

  vec_t vecs[$];

  uart_cmd_decoder #(.TIMEOUT_CLKS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .o_run_stop(o_run_stop),
    .o_clear   (o_clear),
    .o_mode    (o_mode),
    .o_set     (o_set),
    .o_set_hour(o_set_hour),
    .o_set_min (o_set_min),
    .o_err     (o_err)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record one byte and the response expected one cycle after its strobe
  task automatic addVec(input logic [7:0] d, input logic rs, input logic cl,
                        input logic st, input logic er, input logic md,
                        input logic [4:0] hr, input logic [5:0] mn);
    vec_t v;
    v.data = d; v.runStop = rs; v.clear = cl; v.set = st; v.err = er;
    v.mode = md; v.hour = hr; v.min = mn;
    vecs.push_back(v);
  endtask

  // Compare every output against the expected set in one check
  task automatic checkOutput(input string name, input logic rs, input logic cl,
                             input logic st, input logic er, input logic md,
                             input logic [4:0] hr, input logic [5:0] mn);
    checks++;
    if ({o_run_stop, o_clear, o_set, o_err, o_mode, o_set_hour, o_set_min} !==
        {rs, cl, st, er, md, hr, mn}) begin
      errors++;
      $display("[TB] FAIL %s: got run=%0b clr=%0b set=%0b err=%0b mode=%0b h=%0d m=%0d, expected run=%0b clr=%0b set=%0b err=%0b mode=%0b h=%0d m=%0d",
               name, o_run_stop, o_clear, o_set, o_err, o_mode, o_set_hour, o_set_min,
               rs, cl, st, er, md, hr, mn);
    end
  endtask

  // Strobe one byte for one cycle; returns #1 after the sampling edge, where
  // the registered response is visible. Calls chain into back-to-back strobes.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;

    // Stream of commands, all back-to-back
    addVec("R",   1,0,0,0, 0, 5'd0,  6'd0);
    addVec("c",   0,1,0,0, 0, 5'd0,  6'd0);
    addVec("M",   0,0,0,0, 1, 5'd0,  6'd0);
    addVec("m",   0,0,0,0, 0, 5'd0,  6'd0);
    addVec("T",   0,0,0,0, 0, 5'd0,  6'd0);
    addVec("2",   0,0,0,0, 0, 5'd0,  6'd0);
    addVec("3",   0,0,0,0, 0, 5'd0,  6'd0);
    addVec("5",   0,0,0,0, 0, 5'd0,  6'd0);
    addVec("9",   0,0,1,0, 0, 5'd23, 6'd59);
    addVec("T",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("2",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("4",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("6",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("0",   0,0,0,1, 0, 5'd23, 6'd59);
    addVec("T",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("1",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("x",   0,0,0,1, 0, 5'd23, 6'd59);
    addVec("r",   1,0,0,0, 0, 5'd23, 6'd59);
    addVec("t",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("0",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("9",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("0",   0,0,0,0, 0, 5'd23, 6'd59);
    addVec("5",   0,0,1,0, 0, 5'd9,  6'd5);
    addVec("T",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("1",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("9",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("6",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("0",   0,0,0,1, 0, 5'd9,  6'd5);
    addVec("T",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("/",   0,0,0,1, 0, 5'd9,  6'd5);
    addVec("T",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("2",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec(":",   0,0,0,1, 0, 5'd9,  6'd5);
    addVec("T",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("2",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("3",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("0",   0,0,0,0, 0, 5'd9,  6'd5);
    addVec("0",   0,0,1,0, 0, 5'd23, 6'd0);
    addVec("A",   0,0,0,1, 0, 5'd23, 6'd0);
    addVec(8'h0A, 0,0,0,0, 0, 5'd23, 6'd0);
    addVec("C",   0,1,0,0, 0, 5'd23, 6'd0);

    // Reset state
    @(posedge clk);
    #1;
    idleCycle();
    checkOutput("reset_state", 0,0,0,0, 0, 5'd0, 6'd0);
    rst = 1'b0;
    idleCycle();
    checkOutput("idle_after_reset", 0,0,0,0, 0, 5'd0, 6'd0);

    // Table-driven stream
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].data);
      checkOutput($sformatf("vec%0d_0x%02h", i, vecs[i].data),
                  vecs[i].runStop, vecs[i].clear, vecs[i].set, vecs[i].err,
                  vecs[i].mode, vecs[i].hour, vecs[i].min);
    end
    idleCycle();
    checkOutput("pulses_clear_after_stream", 0,0,0,0, 0, 5'd23, 6'd0);

    // Timeout: 'T','0' then 16 quiet cycles gives one error on the 16th
    applyStimulus("T");
    applyStimulus("0");
    checkOutput("to_after_digit", 0,0,0,0, 0, 5'd23, 6'd0);
    for (int k = 1; k <= 15; k++) begin
      idleCycle();
      checkOutput($sformatf("to_wait%0d", k), 0,0,0,0, 0, 5'd23, 6'd0);
    end
    idleCycle();
    checkOutput("to_expire_err", 0,0,0,1, 0, 5'd23, 6'd0);
    idleCycle();
    checkOutput("to_single_pulse", 0,0,0,0, 0, 5'd23, 6'd0);
    for (int k = 0; k < 20; k++) idleCycle();
    checkOutput("to_idle_no_err", 0,0,0,0, 0, 5'd23, 6'd0);
    applyStimulus("R");
    checkOutput("to_back_in_idle", 1,0,0,0, 0, 5'd23, 6'd0);

    // Byte arriving in the expiry cycle wins and the command continues
    applyStimulus("T");
    applyStimulus("0");
    for (int k = 1; k <= 15; k++) idleCycle();
    checkOutput("race_before_expiry", 0,0,0,0, 0, 5'd23, 6'd0);
    applyStimulus("1");
    checkOutput("race_byte_wins", 0,0,0,0, 0, 5'd23, 6'd0);
    applyStimulus("3");
    applyStimulus("0");
    checkOutput("race_set_0130", 0,0,1,0, 0, 5'd1, 6'd30);

    // Reset mid-command with a coincident strobe abandons it quietly
    applyStimulus("M");
    checkOutput("mode_before_rst", 0,0,0,0, 1, 5'd1, 6'd30);
    applyStimulus("T");
    applyStimulus("1");
    applyStimulus("2");
    rst     = 1'b1;
    rx_data = "9";
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    checkOutput("rst_mid_cmd", 0,0,0,0, 0, 5'd0, 6'd0);
    idleCycle();
    checkOutput("rst_no_late_pulse", 0,0,0,0, 0, 5'd0, 6'd0);
    applyStimulus("T");
    applyStimulus("0");
    applyStimulus("8");
    applyStimulus("3");
    applyStimulus("0");
    checkOutput("set_0830", 0,0,1,0, 0, 5'd8, 6'd30);
    applyStimulus("Z");
    checkOutput("bad_Z", 0,0,0,1, 0, 5'd8, 6'd30);
    applyStimulus(8'h0D);
    checkOutput("cr_ignored", 0,0,0,0, 0, 5'd8, 6'd30);
    idleCycle();
    checkOutput("final_quiet", 0,0,0,0, 0, 5'd8, 6'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
